seq_chunk_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 12 +
 rtl/chunk_adder.sv | 12 +
 rtl/seq_chunk_adder.sv | 92 +++++++++
 tb/tb_seq_chunk_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared state type, mode encodings and sizing helpers for the chunked adder
package adder_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;
   function automatic int nchunk(int width, int chunk);
      return width / chunk;
   endfunction
   function automatic int cnt_width(int width, int chunk);
      return (width / chunk) > 1 ? $clog2(width / chunk) : 1;
   endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational W-bit adder slice with carry in/out
module chunk_adder #(
   parameter int W = 16
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);
   assign {cout, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/subtract, CHUNK bits per clock through a registered carry,
// with valid/ready handshakes on both sides and a signed-overflow flag
module seq_chunk_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sout,
   output logic             ovf
);
   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int CW = cnt_width(WIDTH, CHUNK);
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   if (WIDTH % CHUNK != 0) begin : g_width_check
      $error("WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [CHUNK-1:0] x, s;
   logic             cout;

   assign x = a_q[cnt_q*CHUNK +: CHUNK];

   chunk_adder #(.W(CHUNK)) u_add (
      .x    (x),
      .y    (b_q[cnt_q*CHUNK +: CHUNK]),
      .cin  (carry_q),
      .s    (s),
      .cout (cout)
   );

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign sout      = {carry_q, res_q};
   // b_q already holds the inverted operand in subtract mode, so one rule covers both
   assign ovf       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_q[WIDTH-1] != a_q[WIDTH-1]);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      if (state_q == IDLE && in_valid) begin
         state_d = RUN;
         a_d     = a;
         b_d     = b ^ {WIDTH{mode == MODE_SUB}};
         carry_d = mode == MODE_SUB;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         res_d[cnt_q*CHUNK +: CHUNK] = s;
         carry_d = cout;
         cnt_d   = cnt_q == LAST ? '0 : cnt_q + 1'b1;
         state_d = cnt_q == LAST ? DONE : RUN;
      end else if (state_q == DONE && out_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
      end
   end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: table vectors, random ops against an arithmetic model, and
// handshake/reset corner sequences on three configurations (64/16, 64/64, 32/8)
module tb_seq_chunk_adder;
   logic        clk, rst_n;
   logic [63:0] a_in, b_in;
   logic        m_in;
   logic [2:0]  iv, ir, ov, of, ordy;
   logic [64:0] so0, so1;
   logic [32:0] so2;
   logic [2:0][64:0] so;
   int n_chk = 0, n_fail = 0;
   int wd[3] = '{64, 64, 32};
   int nc[3] = '{4, 1, 4};

   assign so[0] = so0;
   assign so[1] = so1;
   assign so[2] = {32'b0, so2};

   seq_chunk_adder #(.WIDTH(64), .CHUNK(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_in), .b(b_in),
      .mode(m_in), .out_valid(ov[0]), .out_ready(ordy[0]), .sout(so0), .ovf(of[0]));
   seq_chunk_adder #(.WIDTH(64), .CHUNK(64)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_in), .b(b_in),
      .mode(m_in), .out_valid(ov[1]), .out_ready(ordy[1]), .sout(so1), .ovf(of[1]));
   seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_in[31:0]), .b(b_in[31:0]),
      .mode(m_in), .out_valid(ov[2]), .out_ready(ordy[2]), .sout(so2), .ovf(of[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a, b;
      logic        m;
      logic [64:0] s;
      logic        o;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Reference: add is plain a+b; subtract is a-b offset by 2^w so the top bit is "no borrow"
   function automatic void model(input int w, input logic [63:0] x, input logic [63:0] y,
                                 input logic m, output logic [64:0] r, output logic o);
      logic [64:0] mask, xe, ye;
      logic sx, sy, sr;
      mask = (65'd1 << w) - 65'd1;
      xe = {1'b0, x} & mask;
      ye = {1'b0, y} & mask;
      r = m ? xe + (65'd1 << w) - ye : xe + ye;
      sx = xe[w-1];
      sy = ye[w-1];
      sr = r[w-1];
      o = m ? (sx != sy && sr != sx) : (sx == sy && sr != sx);
   endfunction

   task automatic start(input int k, input logic [63:0] x, input logic [63:0] y, input logic m);
      @(negedge clk);
      a_in = x; b_in = y; m_in = m; iv[k] = 1'b1;
      @(posedge clk);
      #1;
      iv[k] = 1'b0;
      a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom}; m_in = ~m;
   endtask

   task automatic wait_valid(input int k, output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!ov[k] && lat < 20);
   endtask

   task automatic ack(input int k, input string nm);
      @(negedge clk);
      ordy[k] = 1'b1;
      @(posedge clk);
      #1;
      ordy[k] = 1'b0;
      chk({nm, " valid drop"}, 65'(ov[k]), 65'd0);
      chk({nm, " ready back"}, 65'(ir[k]), 65'd1);
   endtask

   task automatic op(input int k, input logic [63:0] x, input logic [63:0] y, input logic m,
                     input logic [64:0] es, input logic eo, input string nm);
      int lat;
      start(k, x, y, m);
      wait_valid(k, lat);
      chk({nm, " latency"}, 65'(lat), 65'(nc[k]));
      chk({nm, " sout"}, so[k], es);
      chk({nm, " ovf"}, 65'(of[k]), 65'(eo));
      ack(k, nm);
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 4))
         0: return 64'd0;
         1: return '1;
         2: return 64'h8000_0000_0000_0000;
         3: return 64'h7FFF_FFFF_FFFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [64:0] es, held;
      logic eo;
      int lat;
      tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, 65'h0_FFFF_FFFF_FFFF_FFFF, 1'b0};
      tbl[1] = '{64'd8446744073709551614, 64'd10000000000000000000, 1'b0, {1'b0, 64'd18446744073709551614}, 1'b0};
      tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 65'h1_0000_0000_0000_0000, 1'b0};
      tbl[3] = '{64'd184, 64'd1256, 1'b0, 65'd1440, 1'b0};
      tbl[4] = '{64'd156596564, 64'd125556, 1'b0, 65'd156722120, 1'b0};
      tbl[5] = '{64'd184, 64'd1256, 1'b1, 65'h0_FFFF_FFFF_FFFF_FBD0, 1'b0};
      tbl[6] = '{64'd1256, 64'd184, 1'b1, 65'h1_0000_0000_0000_0430, 1'b0};
      tbl[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 65'h0_8000_0000_0000_0000, 1'b1};
      tbl[8] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 65'h1_7FFF_FFFF_FFFF_FFFF, 1'b1};

      rst_n = 1'b0; iv = '0; ordy = '0; a_in = '0; b_in = '0; m_in = 1'b0;
      #1;
      chk("reset in_ready", 65'(ir), 65'b111);
      chk("reset out_valid", 65'(ov), 65'd0);
      chk("reset sout", so[0], 65'd0);
      chk("reset ovf", 65'(of), 65'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 9; i++)
            op(k, tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].s, tbl[i].o, $sformatf("tbl%0d dut%0d", i, k));
      for (int i = 0; i < 9; i++) begin
         model(32, tbl[i].a, tbl[i].b, tbl[i].m, es, eo);
         op(2, tbl[i].a, tbl[i].b, tbl[i].m, es, eo, $sformatf("tbl%0d dut2", i));
      end

      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 25; i++) begin
            logic [63:0] x, y;
            logic m;
            x = pick(); y = pick(); m = 1'($urandom);
            model(wd[k], x, y, m, es, eo);
            op(k, x, y, m, es, eo, $sformatf("rand%0d dut%0d", i, k));
         end

      // Backpressure: result held, new request refused until the output handshake
      model(64, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, es, eo);
      start(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
      wait_valid(0, lat);
      chk("bp sout", so[0], es);
      held = so[0];
      @(negedge clk);
      a_in = 64'd5; b_in = 64'd7; m_in = 1'b0; iv[0] = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         chk("bp hold sout", so[0], held);
         chk("bp hold in_ready", 65'(ir[0]), 65'd0);
         chk("bp hold out_valid", 65'(ov[0]), 65'd1);
      end
      @(negedge clk);
      iv[0] = 1'b0; ordy[0] = 1'b1;
      @(posedge clk);
      #1;
      ordy[0] = 1'b0;
      chk("bp release valid", 65'(ov[0]), 65'd0);
      chk("bp release ready", 65'(ir[0]), 65'd1);
      repeat (6) @(posedge clk);
      #1;
      chk("bp no stray op", 65'(ov[0]), 65'd0);
      chk("bp still idle", 65'(ir[0]), 65'd1);

      // Reset in the middle of RUN
      start(0, tbl[3].a, tbl[3].b, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst run in_ready", 65'(ir[0]), 65'd1);
      chk("rst run out_valid", 65'(ov[0]), 65'd0);
      chk("rst run sout", so[0], 65'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op(0, tbl[0].a, tbl[0].b, tbl[0].m, tbl[0].s, tbl[0].o, "post rst run");

      // Reset while DONE: out_valid must fall without a clock edge
      start(0, tbl[2].a, tbl[2].b, 1'b0);
      wait_valid(0, lat);
      chk("pre rst done valid", 65'(ov[0]), 65'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst done out_valid", 65'(ov[0]), 65'd0);
      chk("rst done in_ready", 65'(ir[0]), 65'd1);
      @(negedge clk);
      rst_n = 1'b1;
      op(0, tbl[8].a, tbl[8].b, tbl[8].m, tbl[8].s, tbl[8].o, "post rst done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
